i2s_capture_ctrl: RTL and testbench
===================================

// Module: i2s_capture_ctrl
// PURPOSE
//  Sequences capture of stereo PCM words from CHANNELS I2S_RX instances sharing one I2S_CLOCK.
//  Snapshots all channels once per I2S frame and drains them as one word stream (valid/ready) to a sample buffer.
//  Runs a fixed frame count or continuously, and flags frames lost to consumer back-pressure.
// PARAMETERS
//  CHANNELS    4  number of stereo I2S_RX instances; 2*CHANNELS words per frame
//  WIDTH      16  bits per PCM word (matches I2S_RX left/right)
//  LATCH_POSN  2  frame_posn value at which snapshot is taken (RX words stable by then)
// PORTS
//  ck          in   1              system clock (same clock driving I2S_CLOCK)
//  rst_n       in   1              asynchronous active-low reset
//  sck         in   1              I2S bit clock from I2S_CLOCK (synchronous to ck)
//  frame_posn  in   6              bit position in 64-bit frame from I2S_CLOCK
//  rx_data     in   2*CHANNELS*WIDTH  {chN R,chN L,...,ch0 R,ch0 L}, ch0 L at LSBs
//  start       in   1              pulse: begin capture (ignored unless IDLE)
//  stop        in   1              pulse: end capture after the current frame drains
//  frames      in   16             frames to capture; 0 = continuous; sampled on start
//  out_data    out  WIDTH          stream word
//  out_chan    out  $clog2(2*CHANNELS)  word index: 2*ch + (0=L,1=R)
//  out_valid   out  1              out_data/out_chan valid
//  out_ready   in   1              consumer accepts when out_valid & out_ready
//  busy        out  1              high in any state except IDLE
//  done        out  1              one-cycle pulse on return to IDLE after a capture
//  overflow    out  1              sticky: a frame trigger was dropped; cleared on start
// BEHAVIOUR
//  Reset: state IDLE; out_data, out_chan, out_valid, busy, done, overflow, counters = 0.
//  Trigger: sck_rise = sck & !sck_q (sck_q registered on ck); trig = sck_rise & frame_posn==LATCH_POSN.
//  States: IDLE -> (start & !stop) -> WAIT -> trig -> DRAIN -> last word accepted -> WAIT or IDLE.
//   IDLE: start & stop same cycle -> stay IDLE. On start: remaining<=frames, idx<=0, overflow<=0.
//   WAIT: on trig copy rx_data into snapshot reg (same cycle as trig seen), go DRAIN. stop -> IDLE, done.
//   DRAIN: out_valid=1; out_data=snapshot word idx; out_chan=idx. Word held stable until accepted.
//    On accept idx++; after idx==2*CHANNELS-1 accepted: idx<=0; if remaining==1 or stop_pend -> IDLE+done,
//    else remaining-- (unless continuous) and -> WAIT.
//  Latency: first word out_valid 1 ck after trig; back-to-back accepts give 1 word/ck.
//  trig while DRAIN: snapshot NOT overwritten, frame dropped, overflow<=1 (sticky).
//  stop while DRAIN: stop_pend set; current frame completes fully, then IDLE. start while busy ignored.
//  frames==0: continuous until stop. remaining is 16-bit, no wrap (decrements only when non-zero mode).
//  done: single pulse the cycle state re-enters IDLE; never asserted by reset.
//  rst_n low mid-DRAIN: out_valid drops immediately (async), partial frame discarded.
// CONFIGURATION
//  CAPTURE_TSTAMP_EN defined: extra output out_ts (1 bit); each frame's drain is preceded by one
//   timestamp word: out_ts=1, out_data = frame counter [WIDTH-1:0], out_chan=0. Frame counter
//   counts every trig (incl. dropped) since start, wraps at 2^WIDTH. Frame = 2*CHANNELS+1 words.
//  Not defined: no out_ts port, no frame counter; frame = 2*CHANNELS words.
// STRUCTURE
//  Shared include i2s_defs.vh: FRAME_BITS=6, FRAME_LEN=64, state encodings ST_IDLE/ST_WAIT/ST_DRAIN.
//  Sub-module i2s_frame_sync: sck edge detect + frame_posn compare -> one-ck trig pulse.
//  Top holds FSM, snapshot register, word mux, counters.
// TESTING
//  CHANNELS=2, frames=3, out_ready=1: exactly 12 words, out_chan 0,1,2,3 repeating, done once, busy low after.
//  rx_data ch0L=16'h8234,ch0R=16'h8235,ch1L=16'h1111,ch1R=16'h2222 -> words in that order, values exact.
//  out_ready low for 70 sck periods mid-drain -> overflow=1, held word unchanged, next frame after drain intact.
//  frames=0, stop pulsed during word 1 -> remaining words of frame delivered, then IDLE + done pulse.
//  start & stop same cycle in IDLE -> busy stays 0, no done; rst_n low during DRAIN -> all outputs 0 at once.
//  CAPTURE_TSTAMP_EN: frames=2 -> out_ts=1 words with data 0 then 1, each followed by 4 PCM words.

Source files
------------

// File: rtl/i2s_capture_ctrl_pkg.sv
// Shared I2S frame constants and capture FSM state encodings.
// Optional CAPTURE_TSTAMP_EN adds one timestamp word to each frame.
package i2s_capture_ctrl_pkg;

  localparam int FRAME_BITS = 6;
  localparam int FRAME_LEN  = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic int words_per_frame(input int channels);
`ifdef CAPTURE_TSTAMP_EN
    return 2 * channels + 1;
`else
    return 2 * channels;
`endif
  endfunction

endpackage

// File: rtl/i2s_frame_sync.sv
// Purpose: one-ck frame trigger on the sck rising edge at frame_posn == LATCH_POSN.
// Latency: combinational from sck/frame_posn, using one registered copy of sck.
// Backpressure: none, the trigger is a free-running pulse.
module i2s_frame_sync
  import i2s_capture_ctrl_pkg::*;
#(
  parameter int LATCH_POSN = 2
) (
  input  logic                  ck,
  input  logic                  rst_n,
  input  logic                  sck,
  input  logic [FRAME_BITS-1:0] frame_posn,
  output logic                  trig
);

  logic sck_q;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      sck_q <= 1'b0;
    end else begin
      sck_q <= sck;
    end
  end

  assign trig = sck & ~sck_q & (frame_posn == FRAME_BITS'(LATCH_POSN));

endmodule

// File: rtl/i2s_capture_ctrl.sv
// Purpose: snapshot all I2S_RX channels once per frame, drain as one word stream (CAPTURE_TSTAMP_EN adds out_ts).
// Latency: first word valid 1 ck after the frame trigger, then 1 word/ck while out_ready is high.
// Backpressure: out_ready low holds the current word; triggers arriving mid-drain are dropped and flag overflow.
module i2s_capture_ctrl
  import i2s_capture_ctrl_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 16,
  parameter int LATCH_POSN = 2
) (
  input  logic                            ck,
  input  logic                            rst_n,
  input  logic                            sck,
  input  logic [FRAME_BITS-1:0]           frame_posn,
  input  logic [2*CHANNELS*WIDTH-1:0]     rx_data,
  input  logic                            start,
  input  logic                            stop,
  input  logic [15:0]                     frames,
  output logic [WIDTH-1:0]                out_data,
  output logic [$clog2(2*CHANNELS)-1:0]   out_chan,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow
`ifdef CAPTURE_TSTAMP_EN
  ,
  output logic                            out_ts
`endif
);

  localparam int NCH    = 2 * CHANNELS;
  localparam int CW     = $clog2(NCH);
  localparam int NWORDS = words_per_frame(CHANNELS);
  localparam int IW     = $clog2(NWORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  logic [1:0]           state;
  logic [IW-1:0]        idx;
  logic [15:0]          remaining;
  logic                 stop_pend;
  logic [NCH*WIDTH-1:0] snap;
  logic                 trig;
  logic                 draining;
  logic                 accept;
  logic [CW-1:0]        pcm_idx;
  logic [WIDTH-1:0]     pcm_dat;

  i2s_frame_sync #(
    .LATCH_POSN (LATCH_POSN)
  ) u_frame_sync (
    .ck         (ck),
    .rst_n      (rst_n),
    .sck        (sck),
    .frame_posn (frame_posn),
    .trig       (trig)
  );

  assign draining = (state == ST_DRAIN);
  assign accept   = draining & out_ready;
  assign busy     = (state != ST_IDLE);
  assign out_valid = draining;

`ifdef CAPTURE_TSTAMP_EN
  logic             is_ts;
  logic [WIDTH-1:0] frame_cnt;
  logic [WIDTH-1:0] ts_snap;

  // Word 0 of every frame is the timestamp, PCM words follow at idx 1..NCH.
  assign is_ts   = (idx == '0);
  assign pcm_idx = is_ts ? '0 : CW'(idx - 1'b1);
  assign out_ts  = draining & is_ts;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      ts_snap   <= '0;
    end else begin
      if (state == ST_IDLE && start && !stop) begin
        frame_cnt <= '0;
      end else if (trig && state != ST_IDLE) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (state == ST_WAIT && trig && !stop) begin
        ts_snap <= frame_cnt;
      end
    end
  end
`else
  assign pcm_idx = CW'(idx);
`endif

  assign pcm_dat  = snap[pcm_idx*WIDTH +: WIDTH];
  assign out_chan = draining ? pcm_idx : '0;

`ifdef CAPTURE_TSTAMP_EN
  assign out_data = !draining ? '0 : (is_ts ? ts_snap : pcm_dat);
`else
  assign out_data = draining ? pcm_dat : '0;
`endif

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      remaining <= '0;
      stop_pend <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
      snap      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state     <= ST_WAIT;
            remaining <= frames;
            idx       <= '0;
            overflow  <= 1'b0;
            stop_pend <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (stop) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else if (trig) begin
            snap  <= rx_data;
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The snapshot is owned by the frame in flight, so a new trigger is lost.
          if (trig) begin
            overflow <= 1'b1;
          end
          if (stop) begin
            stop_pend <= 1'b1;
          end
          if (accept) begin
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (remaining == 16'd1 || stop_pend || stop) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end else begin
                // remaining == 0 means continuous capture and stays at zero.
                if (remaining != 16'd0) begin
                  remaining <= remaining - 16'd1;
                end
                state <= ST_WAIT;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Bench for i2s_capture_ctrl: scoreboard fed by a frame-level reference model, checked by a negedge monitor.
module tb_i2s_capture_ctrl;

  localparam int CH = 2;
  localparam int W  = 16;
  localparam int NW = 2 * CH;

  logic            ck = 1'b0;
  logic            rst_n = 1'b0;
  logic            sck = 1'b0;
  logic [5:0]      frame_posn = '0;
  logic [NW*W-1:0] rx_data;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic [15:0]     frames = '0;
  logic [W-1:0]    out_data;
  logic [1:0]      out_chan;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            busy;
  logic            done;
  logic            overflow;
  logic            ts_w;

  localparam logic [NW*W-1:0] FIXED = {16'h2222, 16'h1111, 16'h8235, 16'h8234};

  i2s_capture_ctrl #(.CHANNELS(CH), .WIDTH(W), .LATCH_POSN(2)) dut (
    .ck         (ck),
    .rst_n      (rst_n),
    .sck        (sck),
    .frame_posn (frame_posn),
    .rx_data    (rx_data),
    .start      (start),
    .stop       (stop),
    .frames     (frames),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
`ifdef CAPTURE_TSTAMP_EN
    ,
    .out_ts     (ts_w)
`endif
  );

`ifndef CAPTURE_TSTAMP_EN
  assign ts_w = 1'b0;
`endif

  always #5 ck = ~ck;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // I2S clock source: sck period = 4 ck, frame_posn advances on sck fall, rx words change mid-frame.
  logic [1:0] div = 2'd0;
  bit         fixed_rx = 1'b1;
  initial rx_data = FIXED;
  always @(negedge ck) begin
    div = div + 2'd1;
    if (div == 2'd2) begin
      sck = 1'b1;
    end else if (div == 2'd0) begin
      sck = 1'b0;
      frame_posn = frame_posn + 6'd1;
      if (frame_posn == 6'd40) rx_data = fixed_rx ? FIXED : {$urandom, $urandom};
    end
  end

  // Reference model: capture sessions and frames. A frame is accepted only if the previous
  // frame's words have all been consumed before this edge; otherwise it is lost.
  typedef struct packed {
    logic [W-1:0] d;
    logic [1:0]   c;
    logic         t;
  } word_t;

  word_t       q[$];
  int          cyc = 0;
  int          last_pop_edge = -1;
  bit          active = 1'b0;
  bit          exp_done = 1'b0;
  bit          exp_ovf = 1'b0;
  bit          stop_pend_m = 1'b0;
  bit          sck_prev = 1'b0;
  int          left = 0;
  logic [W-1:0] fcnt = '0;

  always @(posedge ck) begin
    bit trig_m, frame_end, in_frame;
    cyc++;
    trig_m   = sck && !sck_prev && (frame_posn == 6'd2);
    sck_prev = sck;
    exp_done = 1'b0;
    if (!rst_n) begin
      active = 1'b0; exp_ovf = 1'b0; stop_pend_m = 1'b0; left = 0; fcnt = '0;
      sck_prev = 1'b0;
      q.delete();
    end else if (!active) begin
      if (start && !stop) begin
        active = 1'b1; left = frames; exp_ovf = 1'b0; stop_pend_m = 1'b0; fcnt = '0;
      end
    end else begin
      frame_end = (q.size() == 0) && (last_pop_edge == cyc);
      in_frame  = (q.size() != 0) || frame_end;
      if (in_frame) begin
        if (trig_m) begin exp_ovf = 1'b1; fcnt++; end
        if (stop) stop_pend_m = 1'b1;
        if (frame_end) begin
          if (left == 1 || stop_pend_m) begin active = 1'b0; exp_done = 1'b1; end
          else if (left != 0) left--;
        end
      end else if (stop) begin
        active = 1'b0; exp_done = 1'b1;
      end else if (trig_m) begin
`ifdef CAPTURE_TSTAMP_EN
        q.push_back('{d: fcnt, c: 2'd0, t: 1'b1});
`endif
        for (int w = 0; w < NW; w++) q.push_back('{d: rx_data[w*W +: W], c: 2'(w), t: 1'b0});
        fcnt++;
      end
    end
  end

  int word_cnt = 0;
  int done_cnt = 0;

  always @(negedge ck) begin
    if (rst_n) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      if (out_valid && q.size() != 0) begin
        chk("out_data", {16'd0, out_data}, {16'd0, q[0].d});
        chk("out_chan", {30'd0, out_chan}, {30'd0, q[0].c});
        chk("out_ts", {31'd0, ts_w}, {31'd0, q[0].t});
        if (out_ready) begin
          void'(q.pop_front());
          last_pop_edge = cyc + 1;
          word_cnt++;
        end
      end
      chk("busy", {31'd0, busy}, {31'd0, active});
      chk("done", {31'd0, done}, {31'd0, exp_done});
      chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
      if (done) done_cnt++;
    end
  end

  bit rdy_rand = 1'b0;

  task automatic step();
    @(posedge ck);
    #2;
  endtask

  task automatic drive_rdy();
    out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic pulse_start(input logic [15:0] f);
    frames = f;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (active && n < budget) begin
      step();
      drive_rdy();
      n++;
    end
    if (active) begin
      checks++;
      errors++;
      $display("FAIL %s timeout still busy after %0d cycles", nm, budget);
    end
    out_ready = 1'b1;
    step();
    step();
    chk({nm, "_qempty"}, q.size(), 0);
  endtask

  task automatic wait_word(input string nm, input logic [1:0] chan, input int budget);
    int n = 0;
    while (!(out_valid && out_chan == chan) && n < budget) begin
      step();
      n++;
    end
    if (!(out_valid && out_chan == chan)) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for word %0d", nm, chan);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1);
  end

  initial begin
    int wc0, dc0, n;
    repeat (3) step();
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_out_data", {16'd0, out_data}, 0);
    chk("rst_out_chan", {30'd0, out_chan}, 0);
    rst_n = 1'b1;
    repeat (3) step();

    // Fixed-pattern, 3 frames, consumer always ready.
    wc0 = word_cnt; dc0 = done_cnt;
    pulse_start(16'd3);
    wait_idle("A", 2000);
    chk("A_words", word_cnt - wc0, 12);
    chk("A_done_once", done_cnt - dc0, 1);
    chk("A_busy_low", {31'd0, busy}, 0);
    fixed_rx = 1'b0;

    // Random data, random back-pressure.
    wc0 = word_cnt;
    rdy_rand = 1'b1;
    pulse_start(16'd4);
    wait_idle("B", 3000);
    rdy_rand = 1'b0;
    chk("B_words", word_cnt - wc0, 16);

    // Long stall mid-drain drops a frame.
    wc0 = word_cnt;
    pulse_start(16'd3);
    n = 0;
    while (word_cnt < wc0 + 2 && n < 1000) begin step(); n++; end
    out_ready = 1'b0;
    repeat (280) step();
    chk("C_overflow_set", {31'd0, overflow}, 1);
    out_ready = 1'b1;
    wait_idle("C", 3000);
    chk("C_words", word_cnt - wc0, 12);
    chk("C_overflow_sticky", {31'd0, overflow}, 1);

    // Continuous capture, stop during word 1 completes the frame.
    wc0 = word_cnt; dc0 = done_cnt;
    pulse_start(16'd0);
    wait_word("D", 2'd1, 600);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle("D", 600);
    chk("D_words", word_cnt - wc0, 4);
    chk("D_done_once", done_cnt - dc0, 1);

    // Start and stop together in IDLE do nothing.
    dc0 = done_cnt;
    frames = 16'd5; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    repeat (6) begin
      step();
      chk("E_busy", {31'd0, busy}, 0);
    end
    chk("E_no_done", done_cnt - dc0, 0);

    // Reset during drain clears outputs immediately, then a clean capture.
    pulse_start(16'd2);
    wait_word("F", 2'd0, 600);
    step();
    rst_n = 1'b0;
    #1;
    chk("F_rst_valid", {31'd0, out_valid}, 0);
    chk("F_rst_data", {16'd0, out_data}, 0);
    chk("F_rst_chan", {30'd0, out_chan}, 0);
    chk("F_rst_busy", {31'd0, busy}, 0);
    chk("F_rst_done", {31'd0, done}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("F_q_flushed", q.size(), 0);
    wc0 = word_cnt;
    pulse_start(16'd1);
    wait_idle("F", 600);
    chk("F_words", word_cnt - wc0, 4);

    // Continuous capture with random back-pressure and a random stop.
    rdy_rand = 1'b1;
    pulse_start(16'd0);
    n = $urandom_range(300, 900);
    repeat (n) begin step(); drive_rdy(); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle("G", 2000);
    rdy_rand = 1'b0;
    chk("G_busy_low", {31'd0, busy}, 0);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
